// File: rtl/tile_pixel_fetch.sv
// Tile-map pixel pipeline: raster position plus a per-frame scroll offset is looked up in the
// tile map, then the tile ROM. Sideband rides five register stages, in step with pixel_out.
module tile_pixel_fetch #(
    parameter int unsigned MAP_ADDR_WIDTH = 13,
    parameter int unsigned ROM_ADDR_WIDTH = 14,
    parameter int unsigned DATA_WIDTH     = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [9:0]                hcount,
    input  logic [9:0]                vcount,
    input  logic                      de_in,
    input  logic                      hsync_in,
    input  logic                      vsync_in,
    input  logic                      frame_start,
    input  logic [9:0]                scroll_x,
    input  logic [8:0]                scroll_y,
    output logic [MAP_ADDR_WIDTH-1:0] map_addr,
    input  logic [7:0]                map_data,
    output logic [ROM_ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]     rom_data,
    output logic [DATA_WIDTH-1:0]     pixel_out,
    output logic                      de_out,
    output logic                      hsync_out,
    output logic                      vsync_out
);

    logic [9:0] sx_q;
    logic [8:0] sy_q;
    logic [9:0] vx;
    logic [8:0] vy;
    logic       unused_vcount;

    // Stage registers: s0 = map address, s1 = map RAM wait, s2 = ROM address, s3 = ROM wait
    logic [MAP_ADDR_WIDTH-1:0] map_addr_q;
    logic [2:0]                fx0_q, fy0_q, fx1_q, fy1_q;
    logic                      de0_q, hs0_q, vs0_q;
    logic                      de1_q, hs1_q, vs1_q;
    logic [ROM_ADDR_WIDTH-1:0] rom_addr_q;
    logic                      de2_q, hs2_q, vs2_q;
    logic                      de3_q, hs3_q, vs3_q;
    logic [DATA_WIDTH-1:0]     pixel_q;
    logic                      de4_q, hs4_q, vs4_q;

    // Both sums wrap at their own width, so no explicit modulo is needed
    assign vx            = hcount + sx_q;
    assign vy            = vcount[8:0] + sy_q;
    assign unused_vcount = vcount[9];

    always_ff @(posedge clk) begin
        if (rst) begin
            sx_q       <= '0;
            sy_q       <= '0;
            map_addr_q <= '0;
            fx0_q      <= '0;
            fy0_q      <= '0;
            de0_q      <= 1'b0;
            hs0_q      <= 1'b0;
            vs0_q      <= 1'b0;
            fx1_q      <= '0;
            fy1_q      <= '0;
            de1_q      <= 1'b0;
            hs1_q      <= 1'b0;
            vs1_q      <= 1'b0;
            rom_addr_q <= '0;
            de2_q      <= 1'b0;
            hs2_q      <= 1'b0;
            vs2_q      <= 1'b0;
            de3_q      <= 1'b0;
            hs3_q      <= 1'b0;
            vs3_q      <= 1'b0;
            pixel_q    <= '0;
            de4_q      <= 1'b0;
            hs4_q      <= 1'b0;
            vs4_q      <= 1'b0;
        end else begin
            // The pixel sampled on the frame_start edge still sees the old scroll
            if (frame_start) begin
                sx_q <= scroll_x;
                sy_q <= scroll_y;
            end

            map_addr_q <= MAP_ADDR_WIDTH'({vy[8:3], vx[9:3]});
            fx0_q      <= vx[2:0];
            fy0_q      <= vy[2:0];
            de0_q      <= de_in;
            hs0_q      <= hsync_in;
            vs0_q      <= vsync_in;

            fx1_q      <= fx0_q;
            fy1_q      <= fy0_q;
            de1_q      <= de0_q;
            hs1_q      <= hs0_q;
            vs1_q      <= vs0_q;

            rom_addr_q <= ROM_ADDR_WIDTH'({map_data, fy1_q, fx1_q});
            de2_q      <= de1_q;
            hs2_q      <= hs1_q;
            vs2_q      <= vs1_q;

            de3_q      <= de2_q;
            hs3_q      <= hs2_q;
            vs3_q      <= vs2_q;

            pixel_q    <= de3_q ? rom_data : '0;
            de4_q      <= de3_q;
            hs4_q      <= hs3_q;
            vs4_q      <= vs3_q;
        end
    end

    assign map_addr  = map_addr_q;
    assign rom_addr  = rom_addr_q;
    assign pixel_out = pixel_q;
    assign de_out    = de4_q;
    assign hsync_out = hs4_q;
    assign vsync_out = vs4_q;

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Bench for tile_pixel_fetch: memory models for map RAM and tile ROM, a per-cycle reference
// model built from the pixel arithmetic, and directed plus randomized raster stimulus.
module tb_tile_pixel_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  hcount, vcount;
    logic        de_in, hsync_in, vsync_in, frame_start;
    logic [9:0]  scroll_x;
    logic [8:0]  scroll_y;
    logic [12:0] map_addr;
    logic [7:0]  map_data;
    logic [13:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  pixel_out;
    logic        de_out, hsync_out, vsync_out;

    logic [7:0]  map_mem [8192];
    logic [7:0]  rom_mem [16384];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: scroll in effect and a short history of sampled pixels
    int sx_m = 0;
    int sy_m = 0;
    int cyc = 0;
    int last_rst = -100;
    int h_vx [16];
    int h_vy [16];
    bit h_de [16];
    bit h_hs [16];
    bit h_vs [16];

    always #5 clk = ~clk;

    tile_pixel_fetch dut (
        .clk         (clk),
        .rst         (rst),
        .hcount      (hcount),
        .vcount      (vcount),
        .de_in       (de_in),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .frame_start (frame_start),
        .scroll_x    (scroll_x),
        .scroll_y    (scroll_y),
        .map_addr    (map_addr),
        .map_data    (map_data),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .pixel_out   (pixel_out),
        .de_out      (de_out),
        .hsync_out   (hsync_out),
        .vsync_out   (vsync_out)
    );

    // Synchronous map RAM and tile ROM
    always @(posedge clk) begin
        map_data <= map_mem[map_addr];
        rom_data <= rom_mem[rom_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    function automatic int exp_map(int s);
        return (h_vy[s % 16] / 8) * 128 + (h_vx[s % 16] / 8);
    endfunction

    function automatic int exp_rom(int s);
        return int'(map_mem[exp_map(s)]) * 64 + (h_vy[s % 16] % 8) * 8 + (h_vx[s % 16] % 8);
    endfunction

    task automatic check_cycle();
        int s;
        if (last_rst == cyc) chk("map_addr", 32'(map_addr), 0);
        else chk("map_addr", 32'(map_addr), exp_map(cyc));
        if (cyc - 2 > last_rst) chk("rom_addr", 32'(rom_addr), exp_rom(cyc - 2));
        if (cyc - 4 > last_rst) begin
            s = cyc - 4;
            chk("pixel_out", 32'(pixel_out), h_de[s % 16] ? int'(rom_mem[exp_rom(s)]) : 0);
            chk("de_out", 32'(de_out), 32'(h_de[s % 16]));
            chk("hsync_out", 32'(hsync_out), 32'(h_hs[s % 16]));
            chk("vsync_out", 32'(vsync_out), 32'(h_vs[s % 16]));
        end else begin
            chk("flush_pixel", 32'(pixel_out), 0);
            chk("flush_de", 32'(de_out), 0);
            chk("flush_hs", 32'(hsync_out), 0);
            chk("flush_vs", 32'(vsync_out), 0);
        end
    endtask

    // One clock: record what the DUT samples, advance the scroll model, check #1 later
    task automatic tick();
        int s;
        @(posedge clk);
        s = cyc % 16;
        h_vx[s] = (int'(hcount) + sx_m) % 1024;
        h_vy[s] = (int'(vcount) % 512 + sy_m) % 512;
        h_de[s] = de_in;
        h_hs[s] = hsync_in;
        h_vs[s] = vsync_in;
        if (rst) begin
            last_rst = cyc;
            sx_m = 0;
            sy_m = 0;
        end else if (frame_start) begin
            sx_m = int'(scroll_x);
            sy_m = int'(scroll_y);
        end
        #1;
        check_cycle();
        cyc++;
    endtask

    task automatic fill_mems(input int mode);
        for (int i = 0; i < 8192; i++) map_mem[i] = (mode == 2) ? 8'($urandom) : 8'h05;
        for (int i = 0; i < 16384; i++)
            rom_mem[i] = (mode == 0) ? 8'hFF : (mode == 1) ? 8'(i) : 8'($urandom);
    endtask

    // Memory contents change only under a reset long enough to drain the pipeline
    task automatic reset_with(input int mode);
        rst = 1'b1;
        de_in = 1'b0;
        frame_start = 1'b0;
        fill_mems(mode);
        repeat (6) tick();
        rst = 1'b0;
    endtask

    task automatic run_frame(input int lines);
        int v;
        frame_start = 1'b1;
        scroll_x = 10'($urandom);
        scroll_y = 9'($urandom);
        de_in = 1'b0;
        tick();
        frame_start = 1'b0;
        for (int line = 0; line < lines; line++) begin
            v = (line < lines - 6) ? line : 490 + line - (lines - 6);
            for (int h = 0; h < 800; h++) begin
                hcount = 10'(h);
                vcount = 10'(v);
                de_in = (h < 640) && (v < 480);
                hsync_in = (h >= 656) && (h < 752);
                vsync_in = (v >= 490) && (v < 492);
                scroll_x = 10'($urandom);
                scroll_y = 9'($urandom);
                tick();
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        hcount = '0;
        vcount = '0;
        de_in = 1'b0;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        frame_start = 1'b0;
        scroll_x = '0;
        scroll_y = '0;

        // Blanking: ROM reads FF, de low, random syncs
        reset_with(0);
        for (int i = 0; i < 24; i++) begin
            hcount = 10'($urandom_range(0, 799));
            vcount = 10'($urandom_range(0, 524));
            hsync_in = 1'($urandom);
            vsync_in = 1'($urandom);
            tick();
        end
        chk("blank_pixel", 32'(pixel_out), 0);

        // Alignment: map=05, ROM returns low address byte; first sample right after reset
        reset_with(1);
        hcount = 10'd9;
        vcount = 10'd2;
        de_in = 1'b1;
        hsync_in = 1'b0;
        vsync_in = 1'b0;
        tick();
        chk("align_map_addr", 32'(map_addr), 32'h0001);
        tick();
        tick();
        chk("align_rom_addr", 32'(rom_addr), 32'h0151);
        tick();
        chk("align_de_early", 32'(de_out), 0);
        tick();
        chk("align_pixel", 32'(pixel_out), 32'h51);
        chk("align_de", 32'(de_out), 1);

        // Wrap-around through the latched scroll
        reset_with(2);
        scroll_x = 10'd1020;
        scroll_y = 9'd510;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        hcount = 10'd6;
        vcount = 10'd3;
        de_in = 1'b1;
        tick();
        chk("wrap_map_addr", 32'(map_addr), 0);
        tick();
        tick();
        chk("wrap_fine", 32'(rom_addr[5:0]), 32'h0A);

        // Scroll latch timing
        hcount = 10'd16;
        vcount = 10'd0;
        scroll_x = 10'd0;
        scroll_y = 9'd0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        tick();
        chk("latch_col_before", 32'(map_addr[6:0]), 2);
        scroll_x = 10'd8;
        tick();
        chk("latch_col_ignored", 32'(map_addr[6:0]), 2);
        frame_start = 1'b1;
        tick();
        chk("latch_col_pulse", 32'(map_addr[6:0]), 2);
        frame_start = 1'b0;
        tick();
        chk("latch_col_after", 32'(map_addr[6:0]), 3);

        // Reset mid-operation during active video
        for (int i = 0; i < 6; i++) begin
            hcount = 10'($urandom_range(0, 639));
            vcount = 10'($urandom_range(0, 479));
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_de", 32'(de_out), 0);
        hcount = 10'd40;
        vcount = 10'd8;
        hsync_in = 1'b1;
        de_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("rst_drain_de", 32'(de_out), 0);
            chk("rst_drain_pixel", 32'(pixel_out), 0);
            if (i == 0) chk("rst_scroll_zero", 32'(map_addr), 133);
        end
        tick();
        chk("rst_de_back", 32'(de_out), 1);
        chk("rst_hs_back", 32'(hsync_out), 1);
        hsync_in = 1'b0;

        // Raster frames with random tile map, random scroll, and mid-frame scroll noise
        run_frame(40);
        run_frame(36);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
